// File: rtl/contador_ud_modn.sv
// rtl/contador_ud_modn.sv - modulo-N up/down counter with load, wrap/saturate, terminal count and sticky ovf
// Optional compare/match unit enabled by defining CONTADOR_MATCH_EN.
module contador_ud_modn #(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             UD,
    input  logic             LC,
    input  logic [WIDTH-1:0] entradaParalela,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] cuenta,
    output logic             tc,
    output logic             ovf
`ifdef CONTADOR_MATCH_EN
    ,
    input  logic [WIDTH-1:0] valor_cmp,
    output logic             match
`endif
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] cuenta_nxt;
    logic             at_limit;

    assign at_limit = UD ? (cuenta == '0) : (cuenta == MAXV);
    assign tc       = enable & ~LC & at_limit;

    // Counting never leaves 0..MODULO-1: the limit is handled before any +/-1.
    always_comb begin
        cuenta_nxt = cuenta;
        if (LC) begin
            cuenta_nxt = ({1'b0, entradaParalela} > {1'b0, MAXV}) ? MAXV : entradaParalela;
        end else if (enable) begin
            if (at_limit) begin
                if (!SATURATE) begin
                    cuenta_nxt = UD ? MAXV : '0;
                end
            end else begin
                cuenta_nxt = UD ? (cuenta - ONE) : (cuenta + ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cuenta <= '0;
            ovf    <= 1'b0;
        end else begin
            cuenta <= cuenta_nxt;
            if (tc) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef CONTADOR_MATCH_EN
    // Comparing the next value keeps match aligned with the cycle cuenta holds it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match <= 1'b0;
        end else begin
            match <= (cuenta_nxt == valor_cmp);
        end
    end
`endif

endmodule

// File: tb/tb_contador_ud_modn.sv
// tb/tb_contador_ud_modn.sv - directed self-checking bench for contador_ud_modn
module tb_contador_ud_modn;

    logic       clk;
    logic       rst;

    logic       w_en, w_ud, w_lc, w_clr;
    logic [3:0] w_ep;
    logic [3:0] w_cnt;
    logic       w_tc, w_ovf;

    logic       s_en, s_ud, s_lc, s_clr;
    logic [3:0] s_ep;
    logic [3:0] s_cnt;
    logic       s_tc, s_ovf;

    logic       c_en;
    logic [3:0] lo_cnt, hi_cnt;
    logic       lo_tc, lo_ovf, hi_tc, hi_ovf;

`ifdef CONTADOR_MATCH_EN
    logic [3:0] w_cmp, s_cmp, lo_cmp, hi_cmp;
    logic       w_match, s_match, lo_match, hi_match;
`endif

    int nvec;
    int nerr;

    contador_ud_modn #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .enable(w_en), .UD(w_ud), .LC(w_lc),
        .entradaParalela(w_ep), .clr_ovf(w_clr),
        .cuenta(w_cnt), .tc(w_tc), .ovf(w_ovf)
`ifdef CONTADOR_MATCH_EN
        , .valor_cmp(w_cmp), .match(w_match)
`endif
    );

    contador_ud_modn #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .enable(s_en), .UD(s_ud), .LC(s_lc),
        .entradaParalela(s_ep), .clr_ovf(s_clr),
        .cuenta(s_cnt), .tc(s_tc), .ovf(s_ovf)
`ifdef CONTADOR_MATCH_EN
        , .valor_cmp(s_cmp), .match(s_match)
`endif
    );

    contador_ud_modn #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_lo (
        .clk(clk), .rst(rst), .enable(c_en), .UD(1'b0), .LC(1'b0),
        .entradaParalela(4'd0), .clr_ovf(1'b0),
        .cuenta(lo_cnt), .tc(lo_tc), .ovf(lo_ovf)
`ifdef CONTADOR_MATCH_EN
        , .valor_cmp(lo_cmp), .match(lo_match)
`endif
    );

    contador_ud_modn #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_hi (
        .clk(clk), .rst(rst), .enable(lo_tc), .UD(1'b0), .LC(1'b0),
        .entradaParalela(4'd0), .clr_ovf(1'b0),
        .cuenta(hi_cnt), .tc(hi_tc), .ovf(hi_ovf)
`ifdef CONTADOR_MATCH_EN
        , .valor_cmp(hi_cmp), .match(hi_match)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset;
        #1;
        nvec++;
        if (w_cnt !== 4'd0 || w_ovf !== 1'b0) begin
            nerr++;
            $display("FAIL reset_async: cuenta=%0d ovf=%b, want cuenta=0 ovf=0", w_cnt, w_ovf);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if (w_cnt !== 4'd0 || s_cnt !== 4'd0 || lo_cnt !== 4'd0 || hi_cnt !== 4'd0) begin
            nerr++;
            $display("FAIL reset_release: cuenta w=%0d s=%0d lo=%0d hi=%0d, want all 0", w_cnt, s_cnt, lo_cnt, hi_cnt);
        end
    endtask

    task automatic test_wrap_up;
        w_en = 1'b1; w_ud = 1'b0;
        for (int i = 0; i < 10; i++) begin
            nvec++;
            if (w_cnt !== 4'(i) || w_tc !== (i == 9) || w_ovf !== 1'b0) begin
                nerr++;
                $display("FAIL wrap_up step %0d: cuenta=%0d tc=%b ovf=%b, want cuenta=%0d tc=%b ovf=0",
                         i, w_cnt, w_tc, w_ovf, i, (i == 9));
            end
            @(negedge clk);
        end
        w_en = 1'b0;
        nvec++;
        if (w_cnt !== 4'd0 || w_ovf !== 1'b1) begin
            nerr++;
            $display("FAIL wrap_edge: cuenta=%0d ovf=%b, want cuenta=0 ovf=1", w_cnt, w_ovf);
        end
    endtask

    task automatic test_load;
        w_lc = 1'b1; w_en = 1'b1; w_ud = 1'b1; w_ep = 4'd5;
        #1;
        nvec++;
        if (w_tc !== 1'b0) begin
            nerr++;
            $display("FAIL load_tc_low_at_zero: tc=%b, want 0", w_tc);
        end
        @(negedge clk);
        nvec++;
        if (w_cnt !== 4'd5) begin
            nerr++;
            $display("FAIL load_5: cuenta=%0d, want 5", w_cnt);
        end
        w_ep = 4'd14; w_ud = 1'b0;
        @(negedge clk);
        nvec++;
        if (w_cnt !== 4'd9 || w_tc !== 1'b0) begin
            nerr++;
            $display("FAIL load_clamp: cuenta=%0d tc=%b, want cuenta=9 tc=0", w_cnt, w_tc);
        end
        @(negedge clk);
        nvec++;
        if (w_cnt !== 4'd9 || w_ovf !== 1'b1) begin
            nerr++;
            $display("FAIL load_ignores_ovf: cuenta=%0d ovf=%b, want cuenta=9 ovf=1", w_cnt, w_ovf);
        end
        w_lc = 1'b0; w_en = 1'b0; w_clr = 1'b1;
        @(negedge clk);
        w_clr = 1'b0;
        nvec++;
        if (w_cnt !== 4'd9 || w_ovf !== 1'b0) begin
            nerr++;
            $display("FAIL clr_ovf_hold: cuenta=%0d ovf=%b, want cuenta=9 ovf=0", w_cnt, w_ovf);
        end
    endtask

    task automatic test_reset_mid_count;
        w_en = 1'b1; w_ud = 1'b0;
        @(negedge clk);
        w_en = 1'b0;
        nvec++;
        if (w_cnt !== 4'd0 || w_ovf !== 1'b1) begin
            nerr++;
            $display("FAIL pre_reset_wrap: cuenta=%0d ovf=%b, want cuenta=0 ovf=1", w_cnt, w_ovf);
        end
        w_lc = 1'b1; w_ep = 4'd9;
        @(negedge clk);
        w_lc = 1'b0; w_en = 1'b1;
        nvec++;
        if (w_cnt !== 4'd9) begin
            nerr++;
            $display("FAIL pre_reset_load: cuenta=%0d, want 9", w_cnt);
        end
        #2 rst = 1'b0;
        #1;
        nvec++;
        if (w_cnt !== 4'd0 || w_ovf !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid_count: cuenta=%0d ovf=%b, want cuenta=0 ovf=0", w_cnt, w_ovf);
        end
        @(negedge clk);
        w_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_saturate_down;
        int exp_c [5] = '{2, 1, 0, 0, 0};
        s_lc = 1'b1; s_ep = 4'd2;
        @(negedge clk);
        s_lc = 1'b0; s_ud = 1'b1; s_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            nvec++;
            if (s_cnt !== 4'(exp_c[k]) || s_tc !== (k >= 2) || s_ovf !== (k >= 3)) begin
                nerr++;
                $display("FAIL sat_down step %0d: cuenta=%0d tc=%b ovf=%b, want cuenta=%0d tc=%b ovf=%b",
                         k, s_cnt, s_tc, s_ovf, exp_c[k], (k >= 2), (k >= 3));
            end
            @(negedge clk);
        end
        s_en = 1'b0; s_clr = 1'b1;
        @(negedge clk);
        s_clr = 1'b0;
        nvec++;
        if (s_cnt !== 4'd0 || s_ovf !== 1'b0) begin
            nerr++;
            $display("FAIL sat_clr_ovf: cuenta=%0d ovf=%b, want cuenta=0 ovf=0", s_cnt, s_ovf);
        end
        s_lc = 1'b1; s_ep = 4'd9;
        @(negedge clk);
        s_lc = 1'b0; s_ud = 1'b0; s_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nvec++;
        if (s_cnt !== 4'd9 || s_tc !== 1'b1 || s_ovf !== 1'b1) begin
            nerr++;
            $display("FAIL sat_up_hold: cuenta=%0d tc=%b ovf=%b, want cuenta=9 tc=1 ovf=1", s_cnt, s_tc, s_ovf);
        end
        s_en = 1'b0;
    endtask

    task automatic test_set_clr_same_edge;
        w_lc = 1'b1; w_ep = 4'd9;
        @(negedge clk);
        w_lc = 1'b0; w_en = 1'b1; w_ud = 1'b0; w_clr = 1'b1;
        @(negedge clk);
        w_en = 1'b0;
        nvec++;
        if (w_cnt !== 4'd0 || w_ovf !== 1'b1) begin
            nerr++;
            $display("FAIL set_wins_clr: cuenta=%0d ovf=%b, want cuenta=0 ovf=1", w_cnt, w_ovf);
        end
        @(negedge clk);
        w_clr = 1'b0;
        nvec++;
        if (w_ovf !== 1'b0) begin
            nerr++;
            $display("FAIL clr_after_set: ovf=%b, want 0", w_ovf);
        end
    endtask

    task automatic test_cascade;
        c_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (lo_cnt !== 4'(i % 10) || hi_cnt !== 4'(i / 10)) begin
                nvec++;
                nerr++;
                $display("FAIL cascade step %0d: pair=%0d%0d, want %0d%0d", i, hi_cnt, lo_cnt, i / 10, i % 10);
            end
            @(negedge clk);
        end
        nvec++;
        c_en = 1'b0;
        if (lo_cnt !== 4'd0 || hi_cnt !== 4'd0 || hi_ovf !== 1'b1) begin
            nerr++;
            $display("FAIL cascade_rollover: pair=%0d%0d hi_ovf=%b, want 00 hi_ovf=1", hi_cnt, lo_cnt, hi_ovf);
        end
        nvec++;
        if (hi_ovf === 1'b1 && lo_ovf !== 1'b1) begin
            nerr++;
            $display("FAIL cascade_lo_ovf: lo_ovf=%b, want 1", lo_ovf);
        end
    endtask

`ifdef CONTADOR_MATCH_EN
    task automatic test_match;
        w_cmp = 4'd7;
        w_lc = 1'b1; w_ep = 4'd0;
        @(negedge clk);
        w_lc = 1'b0; w_en = 1'b1; w_ud = 1'b0;
        for (int i = 0; i < 12; i++) begin
            nvec++;
            if (w_cnt !== 4'(i % 10) || w_match !== ((i % 10) == 7)) begin
                nerr++;
                $display("FAIL match step %0d: cuenta=%0d match=%b, want cuenta=%0d match=%b",
                         i, w_cnt, w_match, i % 10, ((i % 10) == 7));
            end
            @(negedge clk);
        end
        w_en = 1'b0;
    endtask
`endif

    initial begin
        nvec = 0; nerr = 0;
        rst = 1'b1;
        w_en = 1'b0; w_ud = 1'b0; w_lc = 1'b0; w_clr = 1'b0; w_ep = 4'd0;
        s_en = 1'b0; s_ud = 1'b0; s_lc = 1'b0; s_clr = 1'b0; s_ep = 4'd0;
        c_en = 1'b0;
`ifdef CONTADOR_MATCH_EN
        w_cmp = 4'd0; s_cmp = 4'd0; lo_cmp = 4'd0; hi_cmp = 4'd0;
`endif
        #3 rst = 1'b0;
        test_reset();
        test_wrap_up();
        test_load();
        test_reset_mid_count();
        test_saturate_down();
        test_set_clr_same_edge();
        test_cascade();
`ifdef CONTADOR_MATCH_EN
        test_match();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
